mem_access_unit: RTL

- Load/store front end between the execute stage and the word-only data memory (128 x 32, index = address[6:0], single write enable).
- Accepts one byte, halfword or word load/store request at a time over a valid/ready handshake.
- Builds sub-word stores as read-modify-write and aligns, zero-extends or sign-extends load data.
- Returns one response per request and flags misaligned or out-of-range accesses without touching memory.

---
 rtl/mem_access_unit_if.sv | 39 +++
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_if
// Brief    : Request/response handshake and word-memory bus of mem_access_unit
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_data;
  logic [31:0] mem_address;
  logic [31:0] mem_writedata;
  logic        mem_we;
  logic [31:0] mem_readdata;

  // Unit side: serves requests and masters the memory.
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  mem_readdata,
    output req_ready, resp_valid, resp_err, resp_data,
    output mem_address, mem_writedata, mem_we
  );

  // Environment side: execute stage plus the data memory.
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output mem_readdata,
    input  req_ready, resp_valid, resp_err, resp_data,
    input  mem_address, mem_writedata, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Byte/half/word load-store front end for a word-only data memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int WORD_IDX_W = 7
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mem_access_unit_if.slave  bus
);

  localparam int c_BYTE_ADDR_W = WORD_IDX_W + 2;

  localparam logic [1:0] c_SZ_BYTE = 2'b00;
  localparam logic [1:0] c_SZ_HALF = 2'b01;
  localparam logic [1:0] c_SZ_WORD = 2'b10;
  localparam logic [1:0] c_SZ_BAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Captured request; only the lane offset and low store data outlive capture.
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  logic [31:0] r_mem_address;
  logic [31:0] r_mem_writedata;
  logic        r_resp_err;
  logic [31:0] r_resp_data;

  logic        w_accept;
  logic        w_err;
  logic [31:0] w_addr_hi;
  logic [31:0] w_req_word_idx;
  logic [7:0]  w_rd_byte;
  logic [15:0] w_rd_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_ready;
  logic        w_resp_valid;
  logic        w_mem_we;

  // --------------------------------------------------------------------------
  // Request decode
  // --------------------------------------------------------------------------
  assign w_accept  = bus.req_valid && (r_state == S_IDLE);
  assign w_addr_hi = bus.req_addr >> c_BYTE_ADDR_W;

  assign w_err = (bus.req_size == c_SZ_BAD)
              || ((bus.req_size == c_SZ_HALF) && bus.req_addr[0])
              || ((bus.req_size == c_SZ_WORD) && (bus.req_addr[1:0] != 2'b00))
              || (w_addr_hi != 32'd0);

  assign w_req_word_idx = {{(32 - WORD_IDX_W){1'b0}}, bus.req_addr[WORD_IDX_W+1:2]};

  // --------------------------------------------------------------------------
  // Load alignment / extension and sub-word store merge
  // --------------------------------------------------------------------------
  assign w_rd_byte = bus.mem_readdata[{r_lane, 3'b000} +: 8];
  assign w_rd_half = bus.mem_readdata[{r_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = bus.mem_readdata;
    case (r_size)
      c_SZ_BYTE: w_load_data = {{24{r_signed & w_rd_byte[7]}}, w_rd_byte};
      c_SZ_HALF: w_load_data = {{16{r_signed & w_rd_half[15]}}, w_rd_half};
      default:   w_load_data = bus.mem_readdata;
    endcase
  end

  always_comb begin
    w_merged = bus.mem_readdata;
    if (r_size == c_SZ_BYTE) begin
      w_merged[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_ready      = 1'b0;
    w_resp_valid = 1'b0;
    w_mem_we     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (w_accept) begin
          if (w_err) begin
            w_next = S_RESP;
          end else if (bus.req_we && (bus.req_size == c_SZ_WORD)) begin
            w_next = S_WR;
          end else begin
            w_next = S_RD;
          end
        end
      end
      S_RD: begin
        w_next = r_we ? S_WR : S_RESP;
      end
      S_WR: begin
        // Decoded straight from state so an async reset kills the write at once.
        w_mem_we = 1'b1;
        w_next   = S_RESP;
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we            <= 1'b0;
      r_size          <= 2'b00;
      r_signed        <= 1'b0;
      r_lane          <= 2'b00;
      r_wdata         <= 16'd0;
      r_mem_address   <= 32'd0;
      r_mem_writedata <= 32'd0;
      r_resp_err      <= 1'b0;
      r_resp_data     <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we        <= bus.req_we;
            r_size      <= bus.req_size;
            r_signed    <= bus.req_signed;
            r_lane      <= bus.req_addr[1:0];
            r_wdata     <= bus.req_wdata[15:0];
            r_resp_err  <= w_err;
            r_resp_data <= 32'd0;
            // Rejected requests leave the memory bus untouched.
            if (!w_err) begin
              r_mem_address <= w_req_word_idx;
              if (bus.req_we && (bus.req_size == c_SZ_WORD)) begin
                r_mem_writedata <= bus.req_wdata;
              end
            end
          end
        end
        S_RD: begin
          if (r_we) begin
            r_mem_writedata <= w_merged;
          end else begin
            r_resp_data <= w_load_data;
          end
        end
        S_RESP: begin
          r_resp_err  <= 1'b0;
          r_resp_data <= 32'd0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready     = w_ready;
  assign bus.resp_valid    = w_resp_valid;
  assign bus.resp_err      = r_resp_err;
  assign bus.resp_data     = r_resp_data;
  assign bus.mem_address   = r_mem_address;
  assign bus.mem_writedata = r_mem_writedata;
  assign bus.mem_we        = w_mem_we;

endmodule
`default_nettype wire
